// File: rtl/argmax_pkg.sv
// Shared types and binary32 field constants for the argmax sequencer.
// Optional NaN handling is enabled by defining ARGMAX_NAN_CHECK_EN.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned SIGN_W         = 1;
  localparam int unsigned EXP_W          = 8;
  localparam int unsigned MANT_W         = 23;
  localparam int unsigned FP_W           = SIGN_W + EXP_W + MANT_W;
  localparam int unsigned MAG_W          = EXP_W + MANT_W;

  // All-ones exponent with a non-zero mantissa.
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[MAG_W-1:MANT_W] == '1) && (x[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/argmax_fp_greater.sv
// Strict greater-than on binary32 scores; +0 and -0 compare equal.
// With ARGMAX_NAN_CHECK_EN, NaN ranks below every other encoding.
module fp_greater
  import argmax_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            a_gt_b
);

  logic             sign_a;
  logic             sign_b;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;

  assign sign_a = a[FP_W-1];
  assign sign_b = b[FP_W-1];
  assign mag_a  = a[MAG_W-1:0];
  assign mag_b  = b[MAG_W-1:0];

  always_comb begin
    a_gt_b = 1'b0;
    if (sign_a != sign_b) begin
      // Opposite signs: positive wins unless both are zeros.
      a_gt_b = !sign_a && ((mag_a | mag_b) != '0);
    end else if (!sign_a) begin
      a_gt_b = mag_a > mag_b;
    end else begin
      a_gt_b = mag_a < mag_b;
    end
`ifdef ARGMAX_NAN_CHECK_EN
    if (fp_is_nan(a)) begin
      a_gt_b = 1'b0;
    end else if (fp_is_nan(b)) begin
      a_gt_b = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/argmax_sequencer.sv
// Streams NUM_CLASSES binary32 scores and reports the index/value of the maximum.
// Define ARGMAX_NAN_CHECK_EN to exclude NaNs from winning and flag them on out_nan.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_nan,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] cnt_q;
  logic             accept;
  logic             begin_pass;
  logic             beat_gt;

  assign accept     = in_ready && in_valid;
  assign begin_pass = (state_q == IDLE) && start;

  fp_greater u_fp_greater (
    .a      (in_data),
    .b      (out_value),
    .a_gt_b (beat_gt)
  );

  // State register; status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == COLLECT);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (accept && (cnt_q == LAST_IDX)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running maximum; only strictly greater beats replace it, so ties keep the earlier index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      out_index <= '0;
      out_value <= '0;
    end else if (begin_pass) begin
      cnt_q     <= '0;
      out_index <= '0;
      out_value <= '0;
    end else if (accept) begin
      cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
      if ((cnt_q == '0) || beat_gt) begin
        out_index <= cnt_q;
        out_value <= in_data;
      end
    end
  end

`ifdef ARGMAX_NAN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_nan <= 1'b0;
    end else if (begin_pass) begin
      out_nan <= 1'b0;
    end else if (accept && fp_is_nan(in_data)) begin
      out_nan <= 1'b1;
    end
  end
`else
  assign out_nan = 1'b0;
`endif

endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed bench for argmax_sequencer with NUM_CLASSES=3 and hand-computed expectations.
module tb_argmax_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned NC    = 3;
  localparam int unsigned IW    = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_value;
  logic          out_nan;
  logic          busy;

  int errors = 0;
  int checks = 0;

  argmax_sequencer #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC),
    .IDX_W       (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value),
    .out_nan   (out_nan),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pass: start, three beats with optional bubbles, result check, optional stall, handshake.
  task automatic run_pass(input string name,
                          input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                          input int gap, input int hold,
                          input logic [1:0] eidx, input logic [31:0] eval, input logic enan);
    logic [31:0] beats [3];
    beats[0] = v0;
    beats[1] = v1;
    beats[2] = v2;
    out_ready = (hold == 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      tick();
    end
    in_valid = 1'b0;
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".index"}, 32'(out_index), 32'(eidx));
    check({name, ".value"}, out_value, eval);
    check({name, ".nan"}, 32'(out_nan), 32'(enan));
    check({name, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h7F80_0000;
      tick();
      check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({name, ".hold_index"}, 32'(out_index), 32'(eidx));
      check({name, ".hold_value"}, out_value, eval);
      check({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, ".released"}, 32'(out_valid), 32'd0);
    check({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic nan_en;
`ifdef ARGMAX_NAN_CHECK_EN
    nan_en = 1'b1;
`else
    nan_en = 1'b0;
`endif
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.index", 32'(out_index), 32'd0);
    check("rst.value", out_value, 32'd0);
    rst_n = 1'b1;
    tick();

    run_pass("pos", 32'h404A1ADF, 32'h0000_0000, 32'h4080_0000, 0, 0, 2'd2, 32'h4080_0000, 1'b0);
    run_pass("neg", 32'hC080_0000, 32'hBF80_0000, 32'hC000_0000, 0, 0, 2'd1, 32'hBF80_0000, 1'b0);
    run_pass("tie", 32'h4080_0000, 32'h4080_0000, 32'h3F80_0000, 0, 0, 2'd0, 32'h4080_0000, 1'b0);
    run_pass("zeros", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 2'd0, 32'h0000_0000, 1'b0);
    run_pass("negzero", 32'h8000_0000, 32'hBF80_0000, 32'h0080_0000, 0, 0, 2'd2, 32'h0080_0000, 1'b0);
    run_pass("inf", 32'hFF80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 0, 0, 2'd1, 32'h7F80_0000, 1'b0);
    if (nan_en) begin
      run_pass("nan", 32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000, 0, 0, 2'd1, 32'h3F80_0000, 1'b1);
      run_pass("allnan", 32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 0, 0, 2'd0, 32'h7FC0_0000, 1'b1);
    end else begin
      run_pass("nan", 32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000, 0, 0, 2'd0, 32'h7FC0_0000, 1'b0);
      run_pass("allnan", 32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 0, 0, 2'd0, 32'h7FC0_0000, 1'b0);
    end
    // Back-to-back after a NaN pass: the sticky flag must clear.
    run_pass("clear", 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 0, 0, 2'd1, 32'h4000_0000, 1'b0);
    run_pass("stall", 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 0, 5, 2'd1, 32'h4000_0000, 1'b0);
    run_pass("bubble", 32'h404A1ADF, 32'h0000_0000, 32'h4080_0000, 2, 0, 2'd2, 32'h4080_0000, 1'b0);

    // Reset in the middle of a pass.
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    tick();
    in_data = 32'h3F80_0000;
    tick();
    in_valid = 1'b0;
    check("mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.in_ready", 32'(in_ready), 32'd0);
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.index", 32'(out_index), 32'd0);
    check("mid.value", out_value, 32'd0);
    check("mid.nan", 32'(out_nan), 32'd0);
    tick();
    check("mid.held_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    run_pass("fresh", 32'hC080_0000, 32'hBF80_0000, 32'hC000_0000, 0, 0, 2'd1, 32'hBF80_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
